// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the 2-way data-cache controller: FSM state encoding,
// default geometry and the way-select type.
package dcache_types;

    localparam int S_OFFSET_DEFAULT = 5;
    localparam int S_INDEX_DEFAULT  = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    typedef logic way_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU request and physical-memory handshake bundle for the cache controller.
// The master modport is the controller's view; slave is the CPU/memory side.
interface dcache_ctrl_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic        mem_resp;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic        pmem_resp;

    modport master (
        input  mem_read, mem_write, mem_address, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address
    );

    modport slave (
        output mem_read, mem_write, mem_address, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address
    );

endinterface

// File: rtl/dcache_ctrl_victim_sel.sv
// Replacement choice for a miss: an invalid way is always preferred,
// otherwise the set's LRU way is evicted.
module dcache_victim_sel
    import dcache_types::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_lru,
    output way_t o_victim
);

    always_comb begin
        if (!i_valid0) begin
            o_victim = 1'b0;
        end else if (!i_valid1) begin
            o_victim = 1'b1;
        end else begin
            o_victim = i_lru;
        end
    end

endmodule

// File: rtl/dcache.sv
// Control FSM of the 2-way set-associative data cache: hit detection, LRU and
// dirty maintenance, victim writeback and line fill over the pmem port.
module dcache_ctrl
    import dcache_types::*;
#(
    parameter  int S_INDEX  = S_INDEX_DEFAULT,
    parameter  int S_OFFSET = S_OFFSET_DEFAULT,
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_ctrl_if.master      bus,
    input  logic [S_TAG-1:0]   i_tag_out0,
    input  logic [S_TAG-1:0]   i_tag_out1,
    input  logic               i_valid_out0,
    input  logic               i_valid_out1,
    input  logic               i_dirty_out0,
    input  logic               i_dirty_out1,
    input  logic               i_lru_out,
    output logic [S_INDEX-1:0] o_rindex,
    output logic [S_INDEX-1:0] o_windex,
    output logic               o_tag_load0,
    output logic               o_tag_load1,
    output logic               o_valid_load0,
    output logic               o_valid_load1,
    output logic               o_dirty_load0,
    output logic               o_dirty_load1,
    output logic               o_lru_load,
    output logic [S_TAG-1:0]   o_tag_in,
    output logic               o_valid_in,
    output logic               o_dirty_in,
    output logic               o_lru_in,
    output logic               o_data_load0,
    output logic               o_data_load1,
    output logic               o_data_src,
    output logic               o_way_sel
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_WRITEBACK = WRITEBACK;
    localparam logic [1:0] ST_FILL      = FILL;

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    way_t               r_victim;
    way_t               w_victim;
    logic [S_TAG-1:0]   w_reqTag;
    logic [S_TAG-1:0]   w_victimTag;
    logic [S_INDEX-1:0] w_index;
    logic               w_req;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    way_t               w_hitWay;
    logic               w_victimDirty;

    assign w_reqTag = bus.mem_address[31 -: S_TAG];
    assign w_index  = bus.mem_address[S_OFFSET +: S_INDEX];
    assign o_rindex = w_index;
    assign o_windex = w_index;
    assign w_req    = bus.mem_read | bus.mem_write;

    // Way 0 takes priority should both ways ever report a hit.
    assign w_hit0   = i_valid_out0 & (i_tag_out0 == w_reqTag);
    assign w_hit1   = i_valid_out1 & (i_tag_out1 == w_reqTag) & ~w_hit0;
    assign w_hit    = w_hit0 | w_hit1;
    assign w_hitWay = ~w_hit0;

    dcache_victim_sel u_victim_sel (
        .i_valid0 (i_valid_out0),
        .i_valid1 (i_valid_out1),
        .i_lru    (i_lru_out),
        .o_victim (w_victim)
    );

    assign w_victimDirty = w_victim ? (i_valid_out1 & i_dirty_out1)
                                    : (i_valid_out0 & i_dirty_out0);
    assign w_victimTag   = r_victim ? i_tag_out1 : i_tag_out0;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    w_nextState = w_victimDirty ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (bus.pmem_resp) w_nextState = ST_FILL;
            end
            ST_FILL: begin
                if (bus.pmem_resp) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The victim is frozen when leaving IDLE so array writes during the fill
    // cannot disturb which way the miss sequence operates on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && w_nextState != ST_IDLE) begin
                r_victim <= w_victim;
            end
        end
    end

    // Outputs are gated by rst_n so a reset kills the memory request and any
    // array write in the very cycle it is asserted.
    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        o_tag_load0      = 1'b0;
        o_tag_load1      = 1'b0;
        o_valid_load0    = 1'b0;
        o_valid_load1    = 1'b0;
        o_dirty_load0    = 1'b0;
        o_dirty_load1    = 1'b0;
        o_lru_load       = 1'b0;
        o_tag_in         = '0;
        o_valid_in       = 1'b0;
        o_dirty_in       = 1'b0;
        o_lru_in         = 1'b0;
        o_data_load0     = 1'b0;
        o_data_load1     = 1'b0;
        o_data_src       = 1'b0;
        o_way_sel        = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_hit) begin
                        bus.mem_resp = 1'b1;
                        o_way_sel    = w_hitWay;
                        o_lru_load   = 1'b1;
                        o_lru_in     = ~w_hitWay;
                        if (bus.mem_write) begin
                            o_data_load0  = ~w_hitWay;
                            o_data_load1  = w_hitWay;
                            o_dirty_load0 = ~w_hitWay;
                            o_dirty_load1 = w_hitWay;
                            o_dirty_in    = 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    bus.pmem_write   = 1'b1;
                    bus.pmem_address = {w_victimTag, w_index, {S_OFFSET{1'b0}}};
                    o_way_sel        = r_victim;
                end
                ST_FILL: begin
                    bus.pmem_read    = 1'b1;
                    bus.pmem_address = {w_reqTag, w_index, {S_OFFSET{1'b0}}};
                    o_way_sel        = r_victim;
                    if (bus.pmem_resp) begin
                        o_data_load0  = ~r_victim;
                        o_data_load1  = r_victim;
                        o_data_src    = 1'b1;
                        o_tag_load0   = ~r_victim;
                        o_tag_load1   = r_victim;
                        o_tag_in      = w_reqTag;
                        o_valid_load0 = ~r_victim;
                        o_valid_load1 = r_victim;
                        o_dirty_load0 = ~r_victim;
                        o_dirty_load1 = r_victim;
                        o_valid_in    = 1'b1;
                        o_dirty_in    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: an associative cache model predicts the
// memory traffic and responses, a monitor checks what the controller presents.
module tb_dcache_ctrl;
    import dcache_types::*;

    localparam int S_INDEX  = 3;
    localparam int S_OFFSET = 5;
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int MAX_WAIT = 300;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

    logic [S_TAG-1:0]   tagOut0, tagOut1, tagIn;
    logic               validOut0, validOut1, dirtyOut0, dirtyOut1, lruOut;
    logic [S_INDEX-1:0] rindex, windex;
    logic               tagLoad0, tagLoad1, validLoad0, validLoad1;
    logic               dirtyLoad0, dirtyLoad1, lruLoad;
    logic               validIn, dirtyIn, lruIn;
    logic               dataLoad0, dataLoad1, dataSrc, waySel;

    dcache_ctrl #(.S_INDEX(S_INDEX), .S_OFFSET(S_OFFSET)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .i_tag_out0    (tagOut0),
        .i_tag_out1    (tagOut1),
        .i_valid_out0  (validOut0),
        .i_valid_out1  (validOut1),
        .i_dirty_out0  (dirtyOut0),
        .i_dirty_out1  (dirtyOut1),
        .i_lru_out     (lruOut),
        .o_rindex      (rindex),
        .o_windex      (windex),
        .o_tag_load0   (tagLoad0),
        .o_tag_load1   (tagLoad1),
        .o_valid_load0 (validLoad0),
        .o_valid_load1 (validLoad1),
        .o_dirty_load0 (dirtyLoad0),
        .o_dirty_load1 (dirtyLoad1),
        .o_lru_load    (lruLoad),
        .o_tag_in      (tagIn),
        .o_valid_in    (validIn),
        .o_dirty_in    (dirtyIn),
        .o_lru_in      (lruIn),
        .o_data_load0  (dataLoad0),
        .o_data_load1  (dataLoad1),
        .o_data_src    (dataSrc),
        .o_way_sel     (waySel)
    );

    // Register arrays the controller drives; contents survive reset.
    logic [S_TAG-1:0] tagArr0 [NUM_SETS] = '{default: '0};
    logic [S_TAG-1:0] tagArr1 [NUM_SETS] = '{default: '0};
    logic validArr0 [NUM_SETS] = '{default: 1'b0};
    logic validArr1 [NUM_SETS] = '{default: 1'b0};
    logic dirtyArr0 [NUM_SETS] = '{default: 1'b0};
    logic dirtyArr1 [NUM_SETS] = '{default: 1'b0};
    logic lruArr    [NUM_SETS] = '{default: 1'b0};

    assign tagOut0   = tagArr0[rindex];
    assign tagOut1   = tagArr1[rindex];
    assign validOut0 = validArr0[rindex];
    assign validOut1 = validArr1[rindex];
    assign dirtyOut0 = dirtyArr0[rindex];
    assign dirtyOut1 = dirtyArr1[rindex];
    assign lruOut    = lruArr[rindex];

    always @(posedge clk) begin
        if (tagLoad0)   tagArr0[windex]   <= tagIn;
        if (tagLoad1)   tagArr1[windex]   <= tagIn;
        if (validLoad0) validArr0[windex] <= validIn;
        if (validLoad1) validArr1[windex] <= validIn;
        if (dirtyLoad0) dirtyArr0[windex] <= dirtyIn;
        if (dirtyLoad1) dirtyArr1[windex] <= dirtyIn;
        if (lruLoad)    lruArr[windex]    <= lruIn;
    end

    // Reference cache: what each set should hold after every request.
    logic [S_TAG-1:0] refTag   [NUM_SETS][2] = '{default: '0};
    bit               refValid [NUM_SETS][2] = '{default: 1'b0};
    bit               refDirty [NUM_SETS][2] = '{default: 1'b0};
    bit               refLru   [NUM_SETS]    = '{default: 1'b0};

    typedef struct {
        logic             isWrite;
        logic [31:0]      addr;
        logic             way;
        logic [S_TAG-1:0] tag;
    } pmemExp_t;

    typedef struct {
        logic way;
        logic isWrite;
        logic lruIn;
    } respExp_t;

    pmemExp_t expPmem [$];
    respExp_t expResp [$];

    int  total = 0;
    int  bad   = 0;
    int  respDelay = 0;
    bit  spuriousResp = 1'b0;
    bit  monitorOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [8:0] loadsVec();
        return {tagLoad0, tagLoad1, validLoad0, validLoad1, dirtyLoad0, dirtyLoad1,
                lruLoad, dataLoad0, dataLoad1};
    endfunction

    task automatic predictRequest(input logic [31:0] addr, input logic isWrite,
                                  output int nTrans);
        int set;
        int way;
        logic [S_TAG-1:0] tag;
        pmemExp_t p;
        respExp_t r;
        set    = int'(addr[7:5]);
        tag    = addr[31:8];
        nTrans = 0;
        if (refValid[set][0] && refTag[set][0] == tag) begin
            way = 0;
        end else if (refValid[set][1] && refTag[set][1] == tag) begin
            way = 1;
        end else begin
            if (!refValid[set][0])      way = 0;
            else if (!refValid[set][1]) way = 1;
            else                        way = int'(refLru[set]);
            if (refValid[set][way] && refDirty[set][way]) begin
                p.isWrite = 1'b1;
                p.addr    = {refTag[set][way], addr[7:5], 5'b0};
                p.way     = way[0];
                p.tag     = refTag[set][way];
                expPmem.push_back(p);
                nTrans++;
            end
            p.isWrite = 1'b0;
            p.addr    = {addr[31:5], 5'b0};
            p.way     = way[0];
            p.tag     = tag;
            expPmem.push_back(p);
            nTrans++;
            refTag[set][way]   = tag;
            refValid[set][way] = 1'b1;
            refDirty[set][way] = 1'b0;
        end
        if (isWrite) refDirty[set][way] = 1'b1;
        refLru[set] = (way == 0);
        r.way     = way[0];
        r.isWrite = isWrite;
        r.lruIn   = (way == 0);
        expResp.push_back(r);
    endtask

    // Drives one request, holds it until mem_resp and checks the latency
    // implied by the number of memory transactions the model predicted.
    task automatic applyStimulus(input logic [31:0] addr, input logic isWrite, input int delay);
        int nTrans;
        int waited;
        int expCycles;
        @(negedge clk);
        respDelay = delay;
        predictRequest(addr, isWrite, nTrans);
        bus.mem_address = addr;
        bus.mem_read    = ~isWrite;
        bus.mem_write   = isWrite;
        waited = 0;
        #1;
        while (!bus.mem_resp && waited < MAX_WAIT) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.mem_resp) begin
            total++;
            bad++;
            $display("[TB] FAIL respTimeout: addr 0x%0h got no mem_resp in %0d cycles", addr, MAX_WAIT);
        end else begin
            expCycles = (nTrans == 0) ? 0 : 1 + nTrans * (delay + 1);
            checkOutput("respLatency", waited, expCycles);
        end
    endtask

    task automatic idleBus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    endtask

    // Memory model: answers a request after respDelay waiting cycles.
    initial begin
        int waitCnt;
        waitCnt = 0;
        bus.pmem_resp = 1'b0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (spuriousResp) begin
                bus.pmem_resp = 1'b1;
                spuriousResp  = 1'b0;
            end else if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                if (waitCnt >= respDelay) begin
                    bus.pmem_resp = 1'b1;
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin
        logic [1:0] prevKind;
        bit         prevHold;
        pmemExp_t   p;
        respExp_t   r;
        prevKind = 2'b00;
        prevHold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || !monitorOn) begin
                prevHold = 1'b0;
            end else begin
                checkOutput("pmemExclusive", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
                if (prevHold) begin
                    checkOutput("pmemHeld", 32'({bus.pmem_read, bus.pmem_write}), 32'(prevKind));
                end
                if (bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
                    if (expPmem.size() == 0) begin
                        checkOutput("unexpectedPmem", bus.pmem_address, 32'hFFFF_FFFF);
                    end else begin
                        p = expPmem.pop_front();
                        checkOutput("pmemWrite", 32'(bus.pmem_write), 32'(p.isWrite));
                        checkOutput("pmemAddr", bus.pmem_address, p.addr);
                        if (p.isWrite) begin
                            checkOutput("wbWaySel", 32'(waySel), 32'(p.way));
                            checkOutput("wbLoads", 32'(loadsVec()), 32'd0);
                        end else begin
                            checkOutput("fillLoads", 32'(loadsVec()),
                                        32'({~p.way, p.way, ~p.way, p.way, ~p.way, p.way,
                                             1'b0, ~p.way, p.way}));
                            checkOutput("fillTagIn", 32'(tagIn), 32'(p.tag));
                            checkOutput("fillValDirty", 32'({validIn, dirtyIn}), 32'b10);
                            checkOutput("fillDataSrc", 32'(dataSrc), 32'd1);
                        end
                    end
                end else if (bus.mem_resp) begin
                    checkOutput("pmemDoneBeforeResp", expPmem.size(), 32'd0);
                    checkOutput("respBusIdle", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
                    if (expResp.size() == 0) begin
                        checkOutput("unexpectedResp", 32'(bus.mem_resp), 32'd0);
                    end else begin
                        r = expResp.pop_front();
                        checkOutput("hitWaySel", 32'(waySel), 32'(r.way));
                        checkOutput("hitLru", 32'({lruLoad, lruIn}), 32'({1'b1, r.lruIn}));
                        checkOutput("hitLoads", 32'({tagLoad0, tagLoad1, validLoad0, validLoad1,
                                                      dirtyLoad0, dirtyLoad1, dataLoad0, dataLoad1}),
                                    32'({4'b0000, r.isWrite & ~r.way, r.isWrite & r.way,
                                         r.isWrite & ~r.way, r.isWrite & r.way}));
                        checkOutput("hitDirtyIn", 32'(dirtyIn), 32'(r.isWrite));
                        checkOutput("hitDataSrc", 32'(dataSrc), 32'd0);
                    end
                end else begin
                    checkOutput("quietLoads", 32'(loadsVec()), 32'd0);
                end
                prevKind = {bus.pmem_read, bus.pmem_write};
                prevHold = (bus.pmem_read || bus.pmem_write) && !bus.pmem_resp;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        int waited;
        rst_n           = 1'b0;
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        bus.mem_address = 32'h1234_5660;
        @(negedge clk);
        #1;
        checkOutput("rstMemResp", 32'(bus.mem_resp), 32'd0);
        checkOutput("rstPmem", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
        checkOutput("rstRindex", 32'(rindex), 32'd3);
        checkOutput("rstWindex", 32'(windex), 32'd3);
        checkOutput("rstLoads", 32'(loadsVec()), 32'd0);
        checkOutput("rstWaySel", 32'(waySel), 32'd0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idleOutputs", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write, waySel,
                                        dataSrc, loadsVec()}), 32'd0);
        checkOutput("idlePmemAddr", bus.pmem_address, 32'd0);
        monitorOn = 1'b1;

        // Abandon a cold miss with a reset while the fill is outstanding.
        respDelay = 50;
        @(negedge clk);
        bus.mem_address = 32'h0000_0040;
        bus.mem_read    = 1'b1;
        waited = 0;
        #1;
        while (!bus.pmem_read && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("abortFillStarted", 32'(bus.pmem_read), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abortPmemDrop", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
        checkOutput("abortLoads", 32'({bus.mem_resp, loadsVec()}), 32'd0);
        @(negedge clk);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abortNoWrite", 32'({validArr0[2], validArr1[2]}), 32'd0);

        applyStimulus(32'h0000_0040, 1'b0, 2);
        applyStimulus(32'h0000_0044, 1'b1, 2);
        idleBus(1);
        applyStimulus(32'h0000_1040, 1'b0, 1);
        idleBus(1);
        applyStimulus(32'h0000_2040, 1'b0, 10);
        idleBus(1);

        // A stray memory completion while idle must leave everything alone.
        spuriousResp = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("spuriousQuiet", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write, loadsVec()}),
                    32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2 == 0) ? 32'h0000_2040 : 32'h0000_1040, 1'b0, 0);
        end
        idleBus(1);

        for (int i = 0; i < 160; i++) begin
            addr = {22'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31))};
            applyStimulus(addr, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) idleBus($urandom_range(1, 2));
        end
        idleBus(3);
        monitorOn = 1'b0;

        checkOutput("pmemQueueEmpty", expPmem.size(), 32'd0);
        checkOutput("respQueueEmpty", expResp.size(), 32'd0);
        for (int s = 0; s < NUM_SETS; s++) begin
            checkOutput("finalValid", 32'({validArr0[s], validArr1[s]}),
                        32'({refValid[s][0], refValid[s][1]}));
            if (refValid[s][0]) begin
                checkOutput("finalTag0", 32'(tagArr0[s]), 32'(refTag[s][0]));
                checkOutput("finalDirty0", 32'(dirtyArr0[s]), 32'(refDirty[s][0]));
            end
            if (refValid[s][1]) begin
                checkOutput("finalTag1", 32'(tagArr1[s]), 32'(refTag[s][1]));
                checkOutput("finalDirty1", 32'(dirtyArr1[s]), 32'(refDirty[s][1]));
            end
            checkOutput("finalLru", 32'(lruArr[s]), 32'(refLru[s]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
